// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl
// Time-shared signed multiplier controller. Up to N_REQ requesters post
// operand pairs. A round-robin arbiter picks one of them. A serial shift-add
// engine then forms the signed product A*B, processing one B bit per cycle,
// LSB first. Each result comes back tagged with the index of the requester
// that won arbitration.
//
// Build option:
//   MUL_SHARE_FIXED_PRIO_EN - when defined, arbitration is fixed priority
//                             (lowest index wins) and the round-robin
//                             pointer is not built.
//
// Ports:
//   clk_i     - clock
//   reset_ni  - synchronous, active-low reset
//   req_i     - per-requester request level
//   A_i       - packed signed operands A, requester k at [k*WIDTH_A +: WIDTH_A]
//   B_i       - packed signed operands B, requester k at [k*WIDTH_B +: WIDTH_B]
//   grant_o   - one-hot pulse: the operands of that requester were captured
//   busy_o    - high while the engine is in RUN or DONE
//   valid_o   - one-cycle pulse: Y_o and tag_o carry a new result
//   Y_o       - signed product, held until the next valid_o
//   tag_o     - requester index belonging to Y_o
module mul_share_ctrl #(
    parameter  int N_REQ   = 4,
    parameter  int WIDTH_A = 16,
    parameter  int WIDTH_B = 16,
    localparam int WIDTH_Y = WIDTH_A + WIDTH_B,
    localparam int TAG_W   = $clog2(N_REQ)
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*WIDTH_A-1:0]   A_i,
    input  logic [N_REQ*WIDTH_B-1:0]   B_i,
    output logic [N_REQ-1:0]           grant_o,
    output logic                       busy_o,
    output logic                       valid_o,
    output logic [WIDTH_Y-1:0]         Y_o,
    output logic [TAG_W-1:0]           tag_o
);

    localparam int CNT_W = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH_B - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH_Y-1:0] a_sh;
    logic [WIDTH_B-1:0] b_sh;
    logic [WIDTH_Y-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [TAG_W-1:0]   winner;

    logic               win_found;
    logic [TAG_W-1:0]   win_idx;
    logic [WIDTH_A-1:0] a_sel;
    logic [WIDTH_B-1:0] b_sel;
    logic [WIDTH_Y-1:0] addend;
    logic [WIDTH_Y-1:0] sum;

`ifndef MUL_SHARE_FIXED_PRIO_EN
    logic [TAG_W-1:0]   ptr;
    logic [TAG_W:0]     cand;
`endif

    // Winner selection and operand mux. In round-robin mode the search
    // starts at the pointer and wraps around. The candidate index carries
    // one extra bit so that the sum ptr+i can be folded back below N_REQ
    // even when N_REQ is not a power of two.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        a_sel     = '0;
        b_sel     = '0;
`ifdef MUL_SHARE_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                win_found = 1'b1;
                win_idx   = TAG_W'(i);
            end
        end
`else
        cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (TAG_W+1)'(i);
            if (cand >= (TAG_W+1)'(N_REQ)) begin
                cand = cand - (TAG_W+1)'(N_REQ);
            end
            if (!win_found && req_i[cand[TAG_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[TAG_W-1:0];
            end
        end
`endif
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == TAG_W'(k)) begin
                a_sel = A_i[k*WIDTH_A +: WIDTH_A];
                b_sel = B_i[k*WIDTH_B +: WIDTH_B];
            end
        end
    end

    // One shift-add step. a_sh already holds A<<i. The MSB of B has
    // negative weight in two's complement, so the last step subtracts.
    always_comb begin
        addend = b_sh[0] ? a_sh : '0;
        sum    = (cnt == LAST_BIT) ? (acc - addend) : (acc + addend);
    end

    // Control FSM and datapath registers. All outputs are registered here.
    // Reset overrides everything, including an operation in progress.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            winner  <= '0;
            grant_o <= '0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
            Y_o     <= '0;
            tag_o   <= '0;
`ifndef MUL_SHARE_FIXED_PRIO_EN
            ptr     <= '0;
`endif
        end else begin
            grant_o <= '0;
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        a_sh    <= {{WIDTH_B{a_sel[WIDTH_A-1]}}, a_sel};
                        b_sh    <= b_sel;
                        winner  <= win_idx;
                        grant_o <= N_REQ'(1) << win_idx;
                        acc     <= '0;
                        cnt     <= '0;
                        busy_o  <= 1'b1;
                        state   <= RUN;
`ifndef MUL_SHARE_FIXED_PRIO_EN
                        ptr     <= (win_idx == TAG_W'(N_REQ - 1)) ? '0
                                                                  : win_idx + TAG_W'(1);
`endif
                    end
                end
                RUN: begin
                    acc  <= sum;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        Y_o     <= sum;
                        tag_o   <= winner;
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl
// Directed self-checking bench for mul_share_ctrl (N_REQ=4, 16x16). Inputs
// change on the falling edge and outputs are sampled there. Expected
// products are hand-computed constants. Define MUL_SHARE_FIXED_PRIO_EN for
// both the bench and the design to select the fixed-priority expectations.
module tb_mul_share_ctrl;

    localparam int N_REQ   = 4;
    localparam int WIDTH_A = 16;
    localparam int WIDTH_B = 16;
    localparam int WIDTH_Y = 32;
    localparam int TAG_W   = 2;

    logic                     clk_i = 1'b0;
    logic                     reset_ni;
    logic [N_REQ-1:0]         req_i;
    logic [N_REQ*WIDTH_A-1:0] A_i;
    logic [N_REQ*WIDTH_B-1:0] B_i;
    logic [N_REQ-1:0]         grant_o;
    logic                     busy_o;
    logic                     valid_o;
    logic [WIDTH_Y-1:0]       Y_o;
    logic [TAG_W-1:0]         tag_o;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    mul_share_ctrl #(
        .N_REQ   (N_REQ),
        .WIDTH_A (WIDTH_A),
        .WIDTH_B (WIDTH_B)
    ) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .req_i    (req_i),
        .A_i      (A_i),
        .B_i      (B_i),
        .grant_o  (grant_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .Y_o      (Y_o),
        .tag_o    (tag_o)
    );

    // Free-running clock and a rising-edge counter used to measure spacing.
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycle <= cycle + 1;

    // Hard stop in case some wait is never satisfied.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b);
        A_i[idx*WIDTH_A +: WIDTH_A] = a;
        B_i[idx*WIDTH_B +: WIDTH_B] = b;
    endtask

    // Waits for valid_o for a bounded number of cycles. Returns the number of
    // falling edges counted after the grant cycle.
    task automatic waitValid(output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!valid_o && n < 40);
    endtask

    // Single request on the given mask. Called on a falling edge while the
    // controller is idle.
    task automatic runProduct(input string name, input logic [3:0] mask,
                              input int exp_idx, input logic [31:0] exp_y);
        int n;
        req_i = mask;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput({name, "_grant"}, 64'(grant_o), 64'(4'b0001 << exp_idx));
        checkOutput({name, "_busy"}, 64'(busy_o), 64'(1));
        req_i = '0;
        waitValid(n);
        checkOutput({name, "_latency"}, 64'(n), 64'(16));
        checkOutput({name, "_y"}, 64'(Y_o), 64'(exp_y));
        checkOutput({name, "_tag"}, 64'(tag_o), 64'(exp_idx));
        @(negedge clk_i);
        checkOutput({name, "_valid_pulse"}, 64'(valid_o), 64'(0));
        checkOutput({name, "_idle"}, 64'(busy_o), 64'(0));
        checkOutput({name, "_y_hold"}, 64'(Y_o), 64'(exp_y));
    endtask

    initial begin
        int          n;
        int          nvalid;
        int          bad_onehot;
        int          g3;
        int          last_cyc;
        int          quiet_valids;
        int          exp_tags[5];
        logic [31:0] exp_held[4];

`ifdef MUL_SHARE_FIXED_PRIO_EN
        exp_tags = '{0, 0, 0, 0, 0};
`else
        exp_tags = '{0, 1, 2, 3, 0};
`endif
        exp_held = '{32'd10, 32'd40, 32'd90, 32'd160};

        reset_ni = 1'b0;
        req_i    = '0;
        A_i      = '0;
        B_i      = '0;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_grant", 64'(grant_o), 64'(0));
        checkOutput("rst_busy", 64'(busy_o), 64'(0));
        checkOutput("rst_valid", 64'(valid_o), 64'(0));
        checkOutput("rst_y", 64'(Y_o), 64'(0));
        checkOutput("rst_tag", 64'(tag_o), 64'(0));
        reset_ni = 1'b1;
        @(negedge clk_i);

        // All four requesters hold their requests: A_k=k+1, B_k=10*(k+1).
        for (int k = 0; k < N_REQ; k++) begin
            applyStimulus(k, 16'(k + 1), 16'(10 * (k + 1)));
        end
        nvalid     = 0;
        bad_onehot = 0;
        g3         = 0;
        last_cyc   = 0;
        n          = 0;
        req_i      = 4'b1111;
        while (nvalid < 5 && n < 200) begin
            @(negedge clk_i);
            n++;
            if (grant_o != '0 && $countones(grant_o) != 1) bad_onehot++;
            if (grant_o[3]) g3++;
            if (valid_o) begin
                checkOutput($sformatf("held_tag%0d", nvalid), 64'(tag_o), 64'(exp_tags[nvalid]));
                checkOutput($sformatf("held_y%0d", nvalid), 64'(Y_o),
                            64'(exp_held[exp_tags[nvalid]]));
                if (nvalid > 0) begin
                    checkOutput($sformatf("held_gap%0d", nvalid), 64'(cycle - last_cyc), 64'(18));
                end
                last_cyc = cycle;
                nvalid++;
            end
        end
        req_i = '0;
        checkOutput("held_count", 64'(nvalid), 64'(5));
        checkOutput("held_onehot", 64'(bad_onehot), 64'(0));
`ifdef MUL_SHARE_FIXED_PRIO_EN
        checkOutput("held_req3_grants", 64'(g3), 64'(0));
`else
        checkOutput("held_req3_grants", 64'(g3), 64'(1));
`endif
        repeat (2) @(negedge clk_i);

        // Basic and corner products through single requests.
        applyStimulus(0, 16'hFFFD, 16'd5);
        runProduct("basic", 4'b0001, 0, 32'hFFFF_FFF1);
        applyStimulus(1, 16'h8000, 16'h8000);
        runProduct("minmin", 4'b0010, 1, 32'h4000_0000);
        applyStimulus(2, 16'h7FFF, 16'h8000);
        runProduct("maxmin", 4'b0100, 2, 32'hC000_8000);
        applyStimulus(0, 16'h0000, 16'hFFFF);
        runProduct("zero", 4'b0001, 0, 32'h0000_0000);

        // Operands change right after the grant: 100 * -7 = -700.
        applyStimulus(1, 16'd100, 16'hFFF9);
        req_i = 4'b0010;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("chg_grant", 64'(grant_o), 64'(4'b0010));
        req_i = '0;
        applyStimulus(1, 16'd5, 16'd5);
        waitValid(n);
        checkOutput("chg_latency", 64'(n), 64'(16));
        checkOutput("chg_y", 64'(Y_o), 64'(32'hFFFF_FD44));
        checkOutput("chg_tag", 64'(tag_o), 64'(1));
        @(negedge clk_i);

        applyStimulus(3, 16'd7, 16'hFFFE);
        runProduct("neg", 4'b1000, 3, 32'hFFFF_FFF2);

        // Reset for one cycle in RUN cycle 8 aborts the product.
        applyStimulus(2, 16'd9, 16'd9);
        req_i = 4'b0100;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("abort_grant", 64'(grant_o), 64'(4'b0100));
        req_i = '0;
        repeat (7) @(negedge clk_i);
        reset_ni = 1'b0;
        @(negedge clk_i);
        checkOutput("abort_grant_clr", 64'(grant_o), 64'(0));
        checkOutput("abort_busy", 64'(busy_o), 64'(0));
        checkOutput("abort_valid", 64'(valid_o), 64'(0));
        checkOutput("abort_y", 64'(Y_o), 64'(0));
        checkOutput("abort_tag", 64'(tag_o), 64'(0));
        reset_ni = 1'b1;
        quiet_valids = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (valid_o) quiet_valids++;
        end
        checkOutput("abort_no_valid", 64'(quiet_valids), 64'(0));

        // After reset the pointer is 0, so requester 2 beats requester 3.
        applyStimulus(2, 16'hFFFD, 16'd5);
        applyStimulus(3, 16'd1, 16'd1);
        runProduct("after_reset", 4'b1100, 2, 32'hFFFF_FFF1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Time-shared signed multiplier controller for the control-loop datapath. Up to N_REQ requesters post operand pairs and the block arbitrates between them, sequencing one serial shift-add engine (WIDTH_B cycles per product). Each result returns with the winner's index as a tag. It sits between the measurement and filter blocks, which need occasional products, and replaces one hard multiplier per consumer.

## Interface
Parameters:
- N_REQ, 4: number of requesters (2..8).
- WIDTH_A, 16: width of signed operand A.
- WIDTH_B, 16: width of signed operand B; also the number of engine cycles.
- WIDTH_Y, WIDTH_A+WIDTH_B: localparam, result width.
- TAG_W, $clog2(N_REQ): localparam, tag width.

Ports:
- clk_i, in, 1: single clock.
- reset_ni, in, 1: synchronous, active-low reset.
- req_i, in, N_REQ: per-requester request level.
- A_i, in, N_REQ*WIDTH_A: packed operands A; requester k is at [k*WIDTH_A +: WIDTH_A].
- B_i, in, N_REQ*WIDTH_B: packed operands B, same packing.
- grant_o, out, N_REQ: one-hot, one-cycle pulse; the operands of that requester were captured.
- busy_o, out, 1: high in RUN and DONE.
- valid_o, out, 1: one-cycle pulse; Y_o and tag_o are valid.
- Y_o, out, WIDTH_Y: signed product A*B, held until the next valid_o.
- tag_o, out, TAG_W: requester index of Y_o, held with Y_o.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - If req_i != 0, select a winner, capture its A (sign-extended to WIDTH_Y) and B, and latch the winner index.
  - Register grant_o = one-hot(winner), clear the accumulator, set bit counter = 0, and go to RUN.
  - If req_i == 0, stay in IDLE; grant_o = 0.
- RUN, one B bit per cycle, LSB first:
  - If B bit i is 1, add A<<i to the accumulator; for bit WIDTH_B-1, subtract A<<(WIDTH_B-1) instead (two's-complement B).
  - The accumulator is WIDTH_Y bits wide, arithmetic wraps mod 2^WIDTH_Y, and the full product never overflows.
  - When counter == WIDTH_B-1, load Y_o from the final sum, load tag_o with the winner index, and go to DONE.
- DONE: valid_o = 1 for this cycle only, then go to IDLE. req_i is ignored in RUN and DONE.
- Arbitration is round-robin:
  - A pointer holds the highest-priority index; search starts at the pointer and wraps from N_REQ-1 to 0.
  - After a grant to k, the pointer becomes (k+1) mod N_REQ.
  - The pointer resets to 0.
- A requester must deassert req_i or present new operands in the cycle after it sees grant_o. A req_i still held when the FSM returns to IDLE counts as a new request.
- Operands are sampled only on the grant edge; A_i/B_i changes during RUN have no effect.
- Reset values: all outputs are 0, state = IDLE, pointer = 0, accumulator = 0.
- Reset mid-RUN aborts the operation: no valid_o, and Y_o and tag_o are cleared.

## Timing
- Request at IDLE edge t:
  - grant_o high in cycle t+1;
  - RUN covers cycles t+1..t+WIDTH_B;
  - valid_o high in cycle t+WIDTH_B+1;
  - IDLE in cycle t+WIDTH_B+2.
- Throughput is one product per WIDTH_B+2 cycles. With all requesters active, a request waits at most (N_REQ-1)*(WIDTH_B+2) cycles before its grant.
- grant_o, valid_o, Y_o and tag_o are all registered, with no combinational paths from inputs.
- Reset takes effect on the first edge where reset_ni = 0 and overrides every other event in that cycle.

## Configuration
- MUL_SHARE_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest index wins; the pointer logic is not compiled.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- req_i=0001, A0=-3, B0=5 -> grant_o=0001 in cycle t+1; valid_o in cycle t+17; Y_o=0xFFFFFFF1, tag_o=0.
- Corner products, each via a single request:
  - A=-32768, B=-32768 -> Y_o=0x40000000.
  - A=32767, B=-32768 -> Y_o=0xC0008000.
  - A=0, B=-1 -> Y_o=0.
- req_i=1111 held (each requester keeps requesting) -> tags 0,1,2,3,0; 18 cycles between valid_o pulses; grant_o always one-hot.
- Same stimulus with MUL_SHARE_FIXED_PRIO_EN defined -> tags 0,0,0; requester 3 never granted.
- reset_ni low for one cycle at RUN cycle 8 -> no valid_o, all outputs 0; a new request then completes normally with pointer = 0.
- Change A_i/B_i of the granted requester during RUN -> Y_o equals the product of the operands captured at the grant edge.
